// File: rtl/ft_pkg.sv
// Shared definitions for the FT601 245-synchronous-FIFO bus master.
// Holds the FSM state encoding, the default bus width and the byte-enable constant.
package ft_pkg;

    localparam int         DEF_FT_DATA_WIDTH = 32;
    localparam logic [3:0] BE_ALL            = 4'hF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TX_BURST = 3'd1,
        TX_END   = 3'd2,
        RX_OE    = 3'd3,
        RX_BURST = 3'd4,
        RX_END   = 3'd5
    } ft_state_t;

endpackage

// File: rtl/ft601_fifo_master.sv
// FT601 synchronous FIFO master: bursts words from the A2F FIFO to the FT pins (TX)
// and from the FT pins into the F2A FIFO (RX), with TX/RX arbitration and bus turnaround.
module ft601_fifo_master
    import ft_pkg::*;
#(
    parameter int FT_DATA_WIDTH = DEF_FT_DATA_WIDTH,
    parameter int PACKET_WORDS  = 32,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                     ft_clk,
    input  logic                     rst,
    input  logic                     ft_txe_n,
    input  logic                     ft_rxf_n,
    output logic                     ft_oe_n,
    output logic                     ft_wr_n,
    output logic                     ft_rd_n,
    input  logic [FT_DATA_WIDTH-1:0] ft_data_in,
    output logic [FT_DATA_WIDTH-1:0] ft_data_out,
    output logic                     ft_data_oe,
    input  logic [3:0]               ft_be_in,
    output logic [3:0]               ft_be_out,
    input  logic [FT_DATA_WIDTH-1:0] a2f_data,
    input  logic [CNT_WIDTH-1:0]     a2f_count,
    output logic                     a2f_rd,
    output logic [FT_DATA_WIDTH-1:0] f2a_data,
    output logic [3:0]               f2a_be,
    output logic                     f2a_wr,
    input  logic [CNT_WIDTH-1:0]     f2a_free,
    output logic                     tx_active,
    output logic                     rx_active,
    output ft_state_t                o_dbg_state
);

    localparam logic [CNT_WIDTH-1:0] PKT = CNT_WIDTH'(PACKET_WORDS);

    ft_state_t                r_state;
    ft_state_t                w_next;
    logic                     r_prio_tx;
    logic                     w_prio_next;
    logic [CNT_WIDTH-1:0]     r_cnt;

    logic                     r_oe_n, r_wr_n, r_rd_n, r_data_oe, r_tx_act, r_rx_act;
    logic                     w_oe_n, w_wr_n, w_rd_n, w_data_oe, w_tx_act, w_rx_act;
    logic [FT_DATA_WIDTH-1:0] r_f2a_data;
    logic [3:0]               r_f2a_be;
    logic                     r_f2a_wr;

    logic w_tx_ok, w_rx_ok, w_tx_xfer, w_rx_xfer, w_last;

    // Handshake: a word moves on a rising edge only when our strobe (wr_n or rd_n) is
    // already low and the FT601 flag (txe_n or rxf_n) is low in the same cycle; either
    // side going high simply stalls the transfer, nothing is ever dropped.
    assign w_tx_ok   = !ft_txe_n && (a2f_count >= PKT);
    assign w_rx_ok   = !ft_rxf_n && (f2a_free >= PKT);
    assign w_tx_xfer = !r_wr_n && !ft_txe_n && (a2f_count != '0) && (r_cnt < PKT);
    assign w_rx_xfer = !r_rd_n && !ft_rxf_n && (r_cnt < PKT);
    assign w_last    = (r_cnt == PKT - 1'b1);

    always_ff @(posedge ft_clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_prio_tx <= 1'b1;
        end else begin
            r_state   <= w_next;
            r_prio_tx <= w_prio_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_prio_next = r_prio_tx;
        case (r_state)
            IDLE: begin
                if (w_tx_ok && w_rx_ok) begin
                    w_next      = r_prio_tx ? TX_BURST : RX_OE;
                    w_prio_next = !r_prio_tx;
                end else if (w_tx_ok) begin
                    w_next = TX_BURST;
                end else if (w_rx_ok) begin
                    w_next = RX_OE;
                end
            end
            TX_BURST: begin
                if (ft_txe_n || (w_tx_xfer && w_last) || (r_cnt >= PKT))
                    w_next = TX_END;
            end
            TX_END:   w_next = IDLE;
            RX_OE:    w_next = RX_BURST;
            RX_BURST: begin
                if (ft_rxf_n || (w_rx_xfer && w_last) || (r_cnt >= PKT))
                    w_next = RX_END;
            end
            RX_END:   w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Pin strobes are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        w_oe_n    = !((w_next == RX_OE) || (w_next == RX_BURST));
        w_rd_n    = !(w_next == RX_BURST);
        w_wr_n    = !(w_next == TX_BURST);
        w_data_oe = (w_next == TX_BURST);
        w_tx_act  = (w_next == TX_BURST) || (w_next == TX_END);
        w_rx_act  = (w_next == RX_OE) || (w_next == RX_BURST) || (w_next == RX_END);
    end

    always_ff @(posedge ft_clk) begin
        if (rst) begin
            r_oe_n     <= 1'b1;
            r_wr_n     <= 1'b1;
            r_rd_n     <= 1'b1;
            r_data_oe  <= 1'b0;
            r_tx_act   <= 1'b0;
            r_rx_act   <= 1'b0;
            r_cnt      <= '0;
            r_f2a_wr   <= 1'b0;
            r_f2a_data <= '0;
            r_f2a_be   <= '0;
        end else begin
            r_oe_n    <= w_oe_n;
            r_wr_n    <= w_wr_n;
            r_rd_n    <= w_rd_n;
            r_data_oe <= w_data_oe;
            r_tx_act  <= w_tx_act;
            r_rx_act  <= w_rx_act;
            r_f2a_wr  <= w_rx_xfer;
            if (r_state == IDLE)
                r_cnt <= '0;
            else if (w_tx_xfer || w_rx_xfer)
                r_cnt <= r_cnt + 1'b1;
            if (w_rx_xfer) begin
                r_f2a_data <= ft_data_in;
                r_f2a_be   <= ft_be_in;
            end
        end
    end

    assign ft_oe_n     = r_oe_n;
    assign ft_wr_n     = r_wr_n;
    assign ft_rd_n     = r_rd_n;
    assign ft_data_oe  = r_data_oe;
    assign ft_data_out = a2f_data;
    assign ft_be_out   = BE_ALL;
    assign a2f_rd      = w_tx_xfer;
    assign f2a_data    = r_f2a_data;
    assign f2a_be      = r_f2a_be;
    assign f2a_wr      = r_f2a_wr;
    assign tx_active   = r_tx_act;
    assign rx_active   = r_rx_act;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ft601_fifo_master.sv
// Directed bench for ft601_fifo_master: TX/RX bursts, throttling, arbitration,
// flow gates and mid-burst reset, with a small A2F FIFO model and RX expected queues.
module tb_ft601_fifo_master;
    import ft_pkg::*;

    localparam int W   = 32;
    localparam int CW  = 8;

    logic          ft_clk = 1'b0;
    logic          rst = 1'b1;
    logic          ft_txe_n = 1'b1;
    logic          ft_rxf_n = 1'b1;
    logic          ft_oe_n, ft_wr_n, ft_rd_n, ft_data_oe;
    logic [W-1:0]  ft_data_in = '0;
    logic [W-1:0]  ft_data_out;
    logic [3:0]    ft_be_in = '0;
    logic [3:0]    ft_be_out;
    logic [W-1:0]  a2f_data;
    logic [CW-1:0] a2f_count;
    logic          a2f_rd;
    logic [W-1:0]  f2a_data;
    logic [3:0]    f2a_be;
    logic          f2a_wr;
    logic [CW-1:0] f2a_free = '0;
    logic          tx_active, rx_active;
    ft_state_t     dbg_state;

    int a2f_fill = 0;
    int a2f_pops = 0;
    int rx_seq = 0;
    int start = 0;
    int checks = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    logic [3:0]   exp_be_q[$];

    always #5 ft_clk = ~ft_clk;

    // A2F FIFO model: show-ahead head word is derived from the number of pops so far.
    assign a2f_data  = 32'hA500_0000 + 32'(a2f_pops);
    assign a2f_count = CW'(a2f_fill - a2f_pops);
    always @(posedge ft_clk) if (a2f_rd) a2f_pops <= a2f_pops + 1;

    ft601_fifo_master dut (
        .ft_clk      (ft_clk),
        .rst         (rst),
        .ft_txe_n    (ft_txe_n),
        .ft_rxf_n    (ft_rxf_n),
        .ft_oe_n     (ft_oe_n),
        .ft_wr_n     (ft_wr_n),
        .ft_rd_n     (ft_rd_n),
        .ft_data_in  (ft_data_in),
        .ft_data_out (ft_data_out),
        .ft_data_oe  (ft_data_oe),
        .ft_be_in    (ft_be_in),
        .ft_be_out   (ft_be_out),
        .a2f_data    (a2f_data),
        .a2f_count   (a2f_count),
        .a2f_rd      (a2f_rd),
        .f2a_data    (f2a_data),
        .f2a_be      (f2a_be),
        .f2a_wr      (f2a_wr),
        .f2a_free    (f2a_free),
        .tx_active   (tx_active),
        .rx_active   (rx_active),
        .o_dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge ft_clk);
        #2;
    endtask

    task automatic tx_words(input int n, input int first, input string tag);
        for (int i = 0; i < n; i++) begin
            check({tag, "_data"}, ft_data_out, 32'hA500_0000 + 32'(first + i));
            check({tag, "_rd"}, 32'(a2f_rd), 32'd1);
            check({tag, "_wr_n"}, 32'(ft_wr_n), 32'd0);
            check({tag, "_doe"}, 32'(ft_data_oe), 32'd1);
            check({tag, "_be"}, 32'(ft_be_out), 32'hF);
            cyc();
        end
    endtask

    task automatic rx_words(input int n, input string tag);
        for (int j = 0; j < n; j++) begin
            ft_rxf_n   = 1'b0;
            ft_data_in = 32'hC0DE_0000 + 32'(rx_seq);
            ft_be_in   = 4'(rx_seq * 7);
            exp_q.push_back(ft_data_in);
            exp_be_q.push_back(ft_be_in);
            rx_seq++;
            cyc();
            check({tag, "_f2a_wr"}, 32'(f2a_wr), 32'd1);
            check({tag, "_f2a_data"}, f2a_data, exp_q.pop_front());
            check({tag, "_f2a_be"}, 32'(f2a_be), 32'(exp_be_q.pop_front()));
        end
    endtask

    initial begin
        // Reset state
        cyc(); cyc();
        check("rst_oe_n", 32'(ft_oe_n), 32'd1);
        check("rst_wr_n", 32'(ft_wr_n), 32'd1);
        check("rst_rd_n", 32'(ft_rd_n), 32'd1);
        check("rst_doe", 32'(ft_data_oe), 32'd0);
        check("rst_a2f_rd", 32'(a2f_rd), 32'd0);
        check("rst_f2a_wr", 32'(f2a_wr), 32'd0);
        check("rst_act", {30'd0, tx_active, rx_active}, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        cyc();

        // TX burst of 32 from a fill of 40, then gated at 8 and 31
        start = a2f_pops;
        a2f_fill = a2f_pops + 40;
        ft_txe_n = 1'b0;
        cyc();
        check("tx1_state", 32'(dbg_state), 32'(TX_BURST));
        check("tx1_active", 32'(tx_active), 32'd1);
        check("tx1_oe_n", 32'(ft_oe_n), 32'd1);
        tx_words(32, start, "tx1");
        check("tx1_end_state", 32'(dbg_state), 32'(TX_END));
        check("tx1_end_wr_n", 32'(ft_wr_n), 32'd1);
        check("tx1_end_doe", 32'(ft_data_oe), 32'd0);
        check("tx1_end_rd", 32'(a2f_rd), 32'd0);
        check("tx1_pops", 32'(a2f_pops - start), 32'd32);
        cyc();
        check("tx1_idle", 32'(dbg_state), 32'(IDLE));
        a2f_fill = a2f_pops + 31;
        cyc(); cyc();
        check("gate_tx31_state", 32'(dbg_state), 32'(IDLE));
        check("gate_tx31_wr_n", 32'(ft_wr_n), 32'd1);

        // TX throttle after 10 words; word 11 leads the next burst
        start = a2f_pops;
        a2f_fill = a2f_pops + 40;
        cyc();
        check("thr_state", 32'(dbg_state), 32'(TX_BURST));
        tx_words(10, start, "thr");
        ft_txe_n = 1'b1;
        #1;
        check("thr_hold_rd", 32'(a2f_rd), 32'd0);
        check("thr_hold_data", ft_data_out, 32'hA500_0000 + 32'(start + 10));
        cyc();
        check("thr_end_state", 32'(dbg_state), 32'(TX_END));
        check("thr_pops", 32'(a2f_pops - start), 32'd10);
        cyc();
        ft_txe_n = 1'b0;
        cyc();
        check("thr_gate30", 32'(dbg_state), 32'(IDLE));
        a2f_fill = a2f_pops + 32;
        cyc();
        check("thr2_state", 32'(dbg_state), 32'(TX_BURST));
        tx_words(32, start + 10, "thr2");
        ft_txe_n = 1'b1;
        #1;
        check("thr2_end_state", 32'(dbg_state), 32'(TX_END));
        check("thr2_pops", 32'(a2f_pops - start), 32'd42);
        check("thr2_empty_rd", 32'(a2f_rd), 32'd0);
        cyc();

        // RX gate: free space 31 blocks a burst
        ft_rxf_n = 1'b0;
        f2a_free = 8'd31;
        cyc(); cyc(); cyc();
        check("gate_rx31_state", 32'(dbg_state), 32'(IDLE));
        check("gate_rx31_oe_n", 32'(ft_oe_n), 32'd1);
        check("gate_rx31_rd_n", 32'(ft_rd_n), 32'd1);

        // RX burst of 20 words
        f2a_free = 8'd64;
        cyc();
        check("rx1_oe_state", 32'(dbg_state), 32'(RX_OE));
        check("rx1_oe_oe_n", 32'(ft_oe_n), 32'd0);
        check("rx1_oe_rd_n", 32'(ft_rd_n), 32'd1);
        check("rx1_oe_doe", 32'(ft_data_oe), 32'd0);
        check("rx1_active", 32'(rx_active), 32'd1);
        cyc();
        check("rx1_burst_rd_n", 32'(ft_rd_n), 32'd0);
        check("rx1_burst_oe_n", 32'(ft_oe_n), 32'd0);
        rx_words(20, "rx1");
        ft_rxf_n = 1'b1;
        cyc();
        check("rx1_end_wr", 32'(f2a_wr), 32'd0);
        check("rx1_end_state", 32'(dbg_state), 32'(RX_END));
        check("rx1_end_rd_n", 32'(ft_rd_n), 32'd1);
        check("rx1_end_oe_n", 32'(ft_oe_n), 32'd1);
        cyc();
        check("rx1_idle", 32'(dbg_state), 32'(IDLE));
        check("rx1_idle_act", 32'(rx_active), 32'd0);

        // rxf_n rises on the first read cycle: nothing pushed
        ft_rxf_n = 1'b0;
        cyc();
        ft_rxf_n = 1'b1;
        cyc();
        check("rx0_burst_rd_n", 32'(ft_rd_n), 32'd0);
        cyc();
        check("rx0_wr", 32'(f2a_wr), 32'd0);
        check("rx0_end", 32'(dbg_state), 32'(RX_END));
        cyc();

        // Arbitration: both sides ready, bursts alternate TX, RX, TX
        start = a2f_pops;
        a2f_fill = a2f_pops + 64;
        ft_txe_n = 1'b0;
        ft_rxf_n = 1'b0;
        cyc();
        check("arb1_state", 32'(dbg_state), 32'(TX_BURST));
        tx_words(32, start, "arb1");
        check("arb1_end_doe", 32'(ft_data_oe), 32'd0);
        check("arb1_end_oe_n", 32'(ft_oe_n), 32'd1);
        cyc();
        check("arb1_idle", 32'(dbg_state), 32'(IDLE));
        check("arb1_idle_doe", 32'(ft_data_oe), 32'd0);
        check("arb1_idle_oe_n", 32'(ft_oe_n), 32'd1);
        cyc();
        check("arb2_state", 32'(dbg_state), 32'(RX_OE));
        check("arb2_doe", 32'(ft_data_oe), 32'd0);
        cyc();
        rx_words(32, "arb2");
        check("arb2_end_state", 32'(dbg_state), 32'(RX_END));
        check("arb2_end_oe_n", 32'(ft_oe_n), 32'd1);
        check("arb2_end_doe", 32'(ft_data_oe), 32'd0);
        cyc();
        check("arb2_idle", 32'(dbg_state), 32'(IDLE));
        check("arb2_idle_doe", 32'(ft_data_oe), 32'd0);
        cyc();
        check("arb3_state", 32'(dbg_state), 32'(TX_BURST));
        check("arb3_oe_n", 32'(ft_oe_n), 32'd1);
        check("arb3_data", ft_data_out, 32'hA500_0000 + 32'(start + 32));
        ft_txe_n = 1'b1;
        cyc(); cyc();

        // Reset in the middle of an RX burst
        cyc();
        check("mr_oe_state", 32'(dbg_state), 32'(RX_OE));
        cyc();
        rx_words(3, "mr");
        rst = 1'b1;
        cyc();
        check("mr_oe_n", 32'(ft_oe_n), 32'd1);
        check("mr_rd_n", 32'(ft_rd_n), 32'd1);
        check("mr_wr_n", 32'(ft_wr_n), 32'd1);
        check("mr_f2a_wr", 32'(f2a_wr), 32'd0);
        check("mr_state", 32'(dbg_state), 32'(IDLE));
        check("mr_act", {30'd0, tx_active, rx_active}, 32'd0);
        ft_rxf_n = 1'b1;
        rst = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ft601_fifo_master.md
Name: ft601_fifo_master

Overview:
- FT601 245-synchronous-FIFO bus master in the ft_clk domain.
- Moves 32-bit words in bursts between the FT601 pins and two internal FIFOs:
  - A2F FIFO (AFE→FT): source for TX bursts.
  - F2A FIFO (FT→AFE): sink for RX bursts.
- Sits directly between the top-level ft_* pads and the sample FIFOs inside sdr.
- Tri-states are split into in/out/oe; pads are built at top level.

Parameters:
FT_DATA_WIDTH, 32, FT bus width in bits.
PACKET_WORDS, 32, maximum words per burst; also the minimum fill or free space needed to start one.
CNT_WIDTH, 8, width of the FIFO level inputs and the burst counter.

Ports:
ft_clk  in  1  FT601 clock; the only clock.
rst  in  1  synchronous, active-high reset.
ft_txe_n  in  1  FT TX buffer full when high.
ft_rxf_n  in  1  FT RX data available when low.
ft_oe_n  out  1  FT data output enable.
ft_wr_n  out  1  write strobe.
ft_rd_n  out  1  read strobe.
ft_data_in  in  FT_DATA_WIDTH  pad input.
ft_data_out  out  FT_DATA_WIDTH  pad output.
ft_data_oe  out  1  pad drive enable (ft_data and ft_be).
ft_be_in  in  4  byte enables from FT.
ft_be_out  out  4  byte enables to FT.
a2f_data  in  FT_DATA_WIDTH  show-ahead A2F head word.
a2f_count  in  CNT_WIDTH  A2F fill level.
a2f_rd  out  1  A2F pop.
f2a_data  out  FT_DATA_WIDTH  word for F2A.
f2a_be  out  4  byte enables for F2A.
f2a_wr  out  1  F2A push.
f2a_free  in  CNT_WIDTH  F2A free space.
tx_active  out  1  high during TX states (tx_led).
rx_active  out  1  high during RX states (rx_led).

Behaviour:
- Reset values, applied on the next edge even mid-burst:
  - ft_oe_n=ft_wr_n=ft_rd_n=1; ft_data_oe=0; a2f_rd=0; f2a_wr=0; tx_active=rx_active=0.
  - Burst counter=0; state=IDLE; priority=TX.
  - No partial-burst recovery.
- Strobes (oe_n/wr_n/rd_n), ft_data_oe and the active flags are registered, decoded from state.
- States and transitions:
  - IDLE:
    - tx_ok = !ft_txe_n && a2f_count>=PACKET_WORDS.
    - rx_ok = !ft_rxf_n && f2a_free>=PACKET_WORDS.
    - Both ok → use priority flag, then toggle it. Only one ok → take it. Neither → stay in IDLE.
  - TX_BURST:
    - Drive ft_wr_n=0, ft_data_oe=1, ft_data_out=a2f_data, ft_be_out=4'hF.
    - Transfer on any edge where ft_wr_n==0 && ft_txe_n==0; in that cycle a2f_rd=1 (combinational from pin) and counter++.
    - Go to TX_END when the counter reaches PACKET_WORDS or ft_txe_n is sampled high.
    - A word presented while ft_txe_n=1 is not popped; it is retried in a later burst.
  - TX_END: wr_n=1, ft_data_oe=0 for one cycle, then IDLE.
  - RX_OE: ft_oe_n=0, ft_data_oe=0, rd_n=1 for one cycle (bus turnaround).
  - RX_BURST:
    - ft_oe_n=0, ft_rd_n=0.
    - Transfer on edges where ft_rd_n==0 && ft_rxf_n==0: register f2a_data=ft_data_in, f2a_be=ft_be_in, f2a_wr=1 (one-cycle latency), counter++.
    - Go to RX_END on ft_rxf_n high or counter==PACKET_WORDS.
  - RX_END: rd_n=1, then oe_n=1 and ft_data_oe=0 for one cycle, then IDLE.
- Bus turnaround rules:
  - ft_data_oe=1 never coincides with ft_oe_n=0.
  - At least one idle cycle separates TX and RX bursts.
- Counter:
  - Clears on burst entry.
  - Saturates; a burst never exceeds PACKET_WORDS.
  - a2f_rd never asserts when a2f_count==0.
- Simultaneous events:
  - ft_txe_n going high on the same edge as the last counted word → exactly PACKET_WORDS popped, normal TX_END.
  - ft_rxf_n rising on the first RD cycle → zero words pushed.

Decomposition:
- ft_pkg holds:
  - state encoding (IDLE, TX_BURST, TX_END, RX_OE, RX_BURST, RX_END);
  - FT_DATA_WIDTH default;
  - BE_ALL=4'hF.
- No sub-module. The tri-state pad wrapper stays at top level.

Test Plan:
- TX burst: a2f_count=40, txe_n=0 → 32 consecutive a2f_rd pulses, words 0..31 on ft_data_out with wr_n=0, then TX_END and IDLE; the next burst waits until a2f_count>=32.
- TX throttle: txe_n goes high after word 10 → exactly 10 pops, word 11 is held and is the first word of the next burst.
- RX burst: rxf_n=0 for 20 words, f2a_free=64 → oe_n falls one cycle before rd_n, 20 f2a_wr pulses with matching data/be, then oe_n=1 and return to IDLE.
- Arbitration: tx_ok and rx_ok both held true → bursts alternate TX, RX, TX, with ft_data_oe=0 and oe_n=1 on every turnaround cycle.
- Flow gates: f2a_free=31 with rxf_n=0 → no RX start; a2f_count=31 → no TX start.
- Mid-burst reset: rst asserted during RX_BURST → next cycle all strobes high, f2a_wr=0, state=IDLE.
